serial_byte_assembler: RTL and testbench

//  Upstream stage of the byte-flag decoder: deserializes a framed serial bit stream

---
 rtl/serial_byte_assembler_if.sv | 26 ++
 rtl/serial_byte_assembler.sv | 126 ++++++++++++
 tb/tb_serial_byte_assembler.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_assembler_if.sv
// Bundle of serial-input, word-output and status signals for the serial byte assembler.
// The master side drives the serial stream and the downstream ready; the slave side
// is the assembler itself.
interface serial_byte_assembler_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             sof;
  logic             a_ready;
  logic             clr_ovf;
  logic [WIDTH-1:0] a_out;
  logic             a_valid;
  logic             overflow;
  logic             frame_err;

  modport master (
    output bit_in, bit_valid, sof, a_ready, clr_ovf,
    input  a_out, a_valid, overflow, frame_err
  );

  modport slave (
    input  bit_in, bit_valid, sof, a_ready, clr_ovf,
    output a_out, a_valid, overflow, frame_err
  );
endinterface

// File: rtl/serial_byte_assembler.sv
// Serial byte assembler: deserializes a framed bit stream into WIDTH-bit words and
// presents them on a registered valid/ready output slot. Words that complete while
// the slot is still occupied are dropped and flagged in a sticky overflow bit; a
// start-of-frame arriving mid-word restarts the word and pulses frame_err.
module serial_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_byte_assembler_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] a_out_q, a_out_d;
  logic             a_valid_q, a_valid_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;

  logic             complete;
  logic             slot_free;
  logic [CNT_W-1:0] bit_pos;
  logic [CNT_W-1:0] first_pos;

  // Next-state logic: bit capture, word completion, output slot handshake and flags.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    a_out_d     = a_out_q;
    a_valid_d   = a_valid_q;
    overflow_d  = overflow_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;

    // Physical bit positions for the current bit and for word bit 0.
    bit_pos   = LSB_FIRST ? bit_cnt_q : (LAST_CNT - bit_cnt_q);
    first_pos = LSB_FIRST ? '0 : LAST_CNT;
    slot_free = !a_valid_q || bus.a_ready;

    if (bus.bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.sof) begin
            shift_d            = '0;
            shift_d[first_pos] = bus.bit_in;
            bit_cnt_d          = CNT_W'(1);
            state_d            = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.sof) begin
            if (bit_cnt_q != '0) begin
              frame_err_d = 1'b1;
            end
            shift_d            = '0;
            shift_d[first_pos] = bus.bit_in;
            bit_cnt_d          = CNT_W'(1);
          end else begin
            shift_d[bit_pos] = bus.bit_in;
            if (bit_cnt_q == LAST_CNT) begin
              complete  = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end

    if (complete && slot_free) begin
      a_out_d   = shift_d;
      a_valid_d = 1'b1;
    end else if (a_valid_q && bus.a_ready) begin
      a_valid_d = 1'b0;
    end

    if (complete && !slot_free) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      a_out_q     <= '0;
      a_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      a_out_q     <= a_out_d;
      a_valid_q   <= a_valid_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Self-checking bench for serial_byte_assembler. Two instances share one stimulus
// stream: ifA/dutA with LSB_FIRST=1 (main checks) and ifB/dutB with LSB_FIRST=0.
// Expected words are pushed to a scoreboard queue as they are sent and popped when
// the assembler presents them.
module tb_serial_byte_assembler;

  logic clk;
  logic rst_n;

  serial_byte_assembler_if #(.WIDTH(8)) ifA ();
  serial_byte_assembler_if #(.WIDTH(8)) ifB ();

  serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifA)
  );

  serial_byte_assembler #(.WIDTH(8), .LSB_FIRST(1'b0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifB)
  );

  int passCount  = 0;
  int checkCount = 0;
  logic [7:0] expQ[$];
  logic [7:0] expWord;

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of serial input to both instances, then sample point is #1 after the edge.
  task automatic applyStimulus(input logic b, input logic v, input logic s);
    ifA.bit_in = b; ifA.bit_valid = v; ifA.sof = s;
    ifB.bit_in = b; ifB.bit_valid = v; ifB.sof = s;
    @(posedge clk);
    #1;
  endtask

  task automatic setReady(input logic r);
    ifA.a_ready = r;
    ifB.a_ready = r;
  endtask

  task automatic setClr(input logic c);
    ifA.clr_ovf = c;
    ifB.clr_ovf = c;
  endtask

  // Send a full word, bit k of w as the k-th serial bit.
  task automatic sendWord(input logic [7:0] w, input logic withSof);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(w[k], 1'b1, withSof && (k == 0));
    end
  endtask

  task automatic popExpected();
    if (expQ.size() == 0) begin
      expWord = 8'hxx;
      checkCount++;
      $display("[TB] FAIL scoreboard_empty: queue size 0, required at least 1");
    end else begin
      expWord = expQ.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++;
    if (ifA.a_out !== 8'h00) $display("[TB] FAIL reset_a_out: got %h, expected 00", ifA.a_out);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL reset_a_valid: got %b, expected 0", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b, expected 0", ifA.overflow);
    else passCount++;
    checkCount++;
    if (ifA.frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b, expected 0", ifA.frame_err);
    else passCount++;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_word();
    setReady(1'b1);
    expQ.push_back(8'hA5);
    sendWord(8'hA5, 1'b1);
    popExpected();
    checkCount++;
    if (ifA.a_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b, expected 1", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL basic_word: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL basic_valid_drop: got %b, expected 0", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.a_out !== 8'hA5) $display("[TB] FAIL basic_out_kept: got %h, expected a5", ifA.a_out);
    else passCount++;
  endtask

  task automatic test_overflow();
    setReady(1'b0);
    expQ.push_back(8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkCount++;
    if (ifA.frame_err !== 1'b0) $display("[TB] FAIL legal_sof_no_err: got %b, expected 0", ifA.frame_err);
    else passCount++;
    for (int k = 1; k < 8; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL ovf_first_word: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    sendWord(8'h02, 1'b0);
    checkCount++;
    if (ifA.overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b, expected 1", ifA.overflow);
    else passCount++;
    checkCount++;
    if (ifA.a_out !== 8'h01) $display("[TB] FAIL ovf_word_held: got %h, expected 01", ifA.a_out);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b1) $display("[TB] FAIL ovf_valid_held: got %b, expected 1", ifA.a_valid);
    else passCount++;
    setClr(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setClr(1'b0);
    checkCount++;
    if (ifA.overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b, expected 0", ifA.overflow);
    else passCount++;
  endtask

  task automatic test_accept_on_complete();
    logic [7:0] w;
    w = 8'h02;
    setReady(1'b0);
    expQ.push_back(w);
    for (int k = 0; k < 7; k++) applyStimulus(w[k], 1'b1, 1'b0);
    checkCount++;
    if (ifA.a_out !== 8'h01) $display("[TB] FAIL pending_stable: got %h, expected 01", ifA.a_out);
    else passCount++;
    setReady(1'b1);
    applyStimulus(w[7], 1'b1, 1'b0);
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL simul_word: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b1) $display("[TB] FAIL simul_valid: got %b, expected 1", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.overflow !== 1'b0) $display("[TB] FAIL simul_no_ovf: got %b, expected 0", ifA.overflow);
    else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL simul_drain: got %b, expected 0", ifA.a_valid);
    else passCount++;
  endtask

  task automatic test_frame_err();
    logic [7:0] w;
    w = 8'h5A;
    setReady(1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, k == 0);
    expQ.push_back(w);
    applyStimulus(w[0], 1'b1, 1'b1);
    checkCount++;
    if (ifA.frame_err !== 1'b1) $display("[TB] FAIL ferr_pulse: got %b, expected 1", ifA.frame_err);
    else passCount++;
    applyStimulus(w[1], 1'b1, 1'b0);
    checkCount++;
    if (ifA.frame_err !== 1'b0) $display("[TB] FAIL ferr_one_cycle: got %b, expected 0", ifA.frame_err);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL ferr_no_partial: got %b, expected 0", ifA.a_valid);
    else passCount++;
    for (int k = 2; k < 8; k++) applyStimulus(w[k], 1'b1, 1'b0);
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL ferr_word: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
  endtask

  task automatic test_reset_mid_word();
    setReady(1'b1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, k == 0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    checkCount++;
    if (ifA.a_out !== 8'h00) $display("[TB] FAIL rst_mid_a_out: got %h, expected 00", ifA.a_out);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b, expected 0", ifA.a_valid);
    else passCount++;
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkCount++;
    if (ifA.a_valid !== 1'b0) $display("[TB] FAIL rst_ignore_valid: got %b, expected 0", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.a_out !== 8'h00) $display("[TB] FAIL rst_ignore_out: got %h, expected 00", ifA.a_out);
    else passCount++;
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h3C;
    setReady(1'b1);
    expQ.push_back(w);
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < (k % 4); g++) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(w[k], 1'b1, k == 0);
    end
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL gaps_lsb_word: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b1) $display("[TB] FAIL gaps_lsb_valid: got %b, expected 1", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifB.a_out !== 8'h3C) $display("[TB] FAIL gaps_msb_word: got %h, expected 3c", ifB.a_out);
    else passCount++;
    checkCount++;
    if (ifB.a_valid !== 1'b1) $display("[TB] FAIL gaps_msb_valid: got %b, expected 1", ifB.a_valid);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    setReady(1'b1);
    expQ.push_back(8'h96);
    sendWord(8'h96, 1'b0);
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL b2b_first: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    checkCount++;
    if (ifB.a_out !== 8'h69) $display("[TB] FAIL b2b_msb_first: got %h, expected 69", ifB.a_out);
    else passCount++;
    expQ.push_back(8'h4D);
    sendWord(8'h4D, 1'b0);
    popExpected();
    checkCount++;
    if (ifA.a_out !== expWord) $display("[TB] FAIL b2b_second: got %h, expected %h", ifA.a_out, expWord);
    else passCount++;
    checkCount++;
    if (ifA.a_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b, expected 1", ifA.a_valid);
    else passCount++;
    checkCount++;
    if (ifA.overflow !== 1'b0) $display("[TB] FAIL b2b_no_ovf: got %b, expected 0", ifA.overflow);
    else passCount++;
  endtask

  // Main sequence: initialise inputs, run every scenario, print the summary.
  initial begin
    rst_n = 1'b0;
    ifA.bit_in = 1'b0; ifA.bit_valid = 1'b0; ifA.sof = 1'b0;
    ifB.bit_in = 1'b0; ifB.bit_valid = 1'b0; ifB.sof = 1'b0;
    setReady(1'b0);
    setClr(1'b0);
    test_reset();
    test_basic_word();
    test_overflow();
    test_accept_on_complete();
    test_frame_err();
    test_reset_mid_word();
    test_gaps();
    test_back_to_back();
    checkCount++;
    if (expQ.size() != 0) $display("[TB] FAIL scoreboard_drained: %0d words left, expected 0", expQ.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
